// File: rtl/acq_ram_writer_pkg.sv
// Shared definitions for the acquisition-path SRAM byte writer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: write-cycle FSM state encoding, default SRAM address width and
// default write-enable pulse width.
package acq_ram_writer_pkg;

  // Write-cycle phases: address/data setup, active-low strobe, data hold.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } wr_state_e;

  localparam int unsigned ACQ_ADDR_WIDTH = 19;
  localparam int unsigned ACQ_WE_PULSE   = 2;

endpackage

// File: rtl/acq_ram_writer.sv
// Writes bytes strobed in by the disc reader into an asynchronous SRAM.
// Latency: capture at clock E -> SETUP at E+1, we_n low E+2..E+1+WE_PULSE, HOLD at E+2+WE_PULSE.
// Backpressure: none upstream; one pending byte is buffered, further bytes are dropped and flag overrun.
//
// Ports:
//   clock, reset_n          sole clock, asynchronous active-low reset
//   ram_write, ram_data     byte strobe (rising edge = new byte) and its data
//   clear                   synchronous clear of address, count, pending byte and flags
//   sram_addr, sram_dq_out  SRAM address and write data
//   sram_dq_oe, sram_we_n   data bus drive enable, registered active-low write enable
//   byte_count              bytes committed since reset/clear
//   busy, mem_full, overrun status: activity, last address written (sticky), byte dropped (sticky)
module acq_ram_writer
  import acq_ram_writer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ACQ_ADDR_WIDTH,
  parameter int unsigned WE_PULSE   = ACQ_WE_PULSE
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ram_write,
  input  logic [7:0]            ram_data,
  input  logic                  clear,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [7:0]            sram_dq_out,
  output logic                  sram_dq_oe,
  output logic                  sram_we_n,
  output logic [ADDR_WIDTH:0]   byte_count,
  output logic                  busy,
  output logic                  mem_full,
  output logic                  overrun
);

  localparam int unsigned           CNT_W     = $clog2(WE_PULSE + 1);
  localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'(WE_PULSE - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  wr_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            dq_q, dq_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [7:0]            pend_dat_q, pend_dat_d;
  logic                  full_q, full_d;
  logic                  ovr_q, ovr_d;
  logic                  we_n_q, we_n_d;
  logic                  oe_q, oe_d;
  logic                  ram_write_q, ram_write_d;

  logic capture, last_write, accept, to_active, slot_free, to_pend, drop;

  always_comb begin
    ram_write_d = ram_write;
    capture     = ram_write & ~ram_write_q;
    // Completing the write to the top address ends acquisition: no new bytes.
    last_write  = (state_q == ST_HOLD) && (addr_q == ADDR_LAST);
    accept      = capture && !full_q && !last_write;
    // A byte arriving in HOLD with nothing pending starts the next cycle directly.
    to_active   = accept && ((state_q == ST_IDLE) || (state_q == ST_HOLD && !pend_vld_q));
    // The pending slot empties at HOLD exit, so a byte arriving then can take it.
    slot_free   = !pend_vld_q || (state_q == ST_HOLD);
    to_pend     = accept && !to_active && slot_free;
    drop        = accept && !to_active && !slot_free;

    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    dq_d       = dq_q;
    count_d    = count_q;
    pend_vld_d = pend_vld_q;
    pend_dat_d = pend_dat_q;
    full_d     = full_q;
    ovr_d      = ovr_q;

    if (clear) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      addr_d     = '0;
      count_d    = '0;
      pend_vld_d = 1'b0;
      full_d     = 1'b0;
      ovr_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pend_vld_q) begin
            dq_d       = pend_dat_q;
            pend_vld_d = 1'b0;
            state_d    = ST_SETUP;
          end else if (to_active) begin
            dq_d    = ram_data;
            state_d = ST_SETUP;
          end
        end
        ST_SETUP: begin
          cnt_d   = CNT_LOAD;
          state_d = ST_STROBE;
        end
        ST_STROBE: begin
          if (cnt_q == '0) state_d = ST_HOLD;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_HOLD: begin
          count_d = count_q + (ADDR_WIDTH + 1)'(1);
          if (last_write) begin
            full_d     = 1'b1;
            pend_vld_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            if (pend_vld_q) begin
              dq_d       = pend_dat_q;
              pend_vld_d = 1'b0;
              state_d    = ST_SETUP;
            end else if (to_active) begin
              dq_d    = ram_data;
              state_d = ST_SETUP;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (to_pend) begin
        pend_vld_d = 1'b1;
        pend_dat_d = ram_data;
      end
      if (drop) ovr_d = 1'b1;
    end

    // Bus controls come from flops so we_n cannot glitch.
    we_n_d = (state_d != ST_STROBE);
    oe_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      dq_q        <= '0;
      count_q     <= '0;
      pend_vld_q  <= 1'b0;
      pend_dat_q  <= '0;
      full_q      <= 1'b0;
      ovr_q       <= 1'b0;
      we_n_q      <= 1'b1;
      oe_q        <= 1'b0;
      // Reads as "already high" so a strobe held across reset release is ignored.
      ram_write_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      dq_q        <= dq_d;
      count_q     <= count_d;
      pend_vld_q  <= pend_vld_d;
      pend_dat_q  <= pend_dat_d;
      full_q      <= full_d;
      ovr_q       <= ovr_d;
      we_n_q      <= we_n_d;
      oe_q        <= oe_d;
      ram_write_q <= ram_write_d;
    end
  end

  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;
  assign byte_count  = count_q;
  assign busy        = (state_q != ST_IDLE) || pend_vld_q;
  assign mem_full    = full_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_acq_ram_writer.sv
// Bench for acq_ram_writer: directed scenarios plus randomized strobes checked
// every cycle against a write-schedule model (each accepted byte gets a SETUP
// cycle S; outputs at any cycle follow from the list of S values).
module tb_acq_ram_writer;

  localparam int WP  = 2;
  localparam int AW  = 19;
  localparam int AWB = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n, ram_write, clear;
  logic [7:0] ram_data;

  logic [AW-1:0]  a_addr;  logic [7:0] a_dq; logic a_oe, a_we_n, a_busy, a_full, a_ovr;
  logic [AW:0]    a_cnt;
  logic [AWB-1:0] b_addr;  logic [7:0] b_dq; logic b_oe, b_we_n, b_busy, b_full, b_ovr;
  logic [AWB:0]   b_cnt;

  acq_ram_writer #(.ADDR_WIDTH(AW), .WE_PULSE(WP)) dut_a (
    .clock(clock), .reset_n(reset_n), .ram_write(ram_write), .ram_data(ram_data), .clear(clear),
    .sram_addr(a_addr), .sram_dq_out(a_dq), .sram_dq_oe(a_oe), .sram_we_n(a_we_n),
    .byte_count(a_cnt), .busy(a_busy), .mem_full(a_full), .overrun(a_ovr));

  acq_ram_writer #(.ADDR_WIDTH(AWB), .WE_PULSE(WP)) dut_b (
    .clock(clock), .reset_n(reset_n), .ram_write(ram_write), .ram_data(ram_data), .clear(clear),
    .sram_addr(b_addr), .sram_dq_out(b_dq), .sram_dq_oe(b_oe), .sram_we_n(b_we_n),
    .byte_count(b_cnt), .busy(b_busy), .mem_full(b_full), .overrun(b_ovr));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // SRAM images built from what the DUTs strobe out.
  logic [7:0] mem_a [0:255];
  logic [7:0] mem_b [0:7];
  always @(negedge clock) begin
    if (reset_n && !a_we_n) mem_a[a_addr[7:0]] = a_dq;
    if (reset_n && !b_we_n) mem_b[b_addr] = b_dq;
  end

  // ---------------- reference model ----------------
  int         acc_e[$];   // capture cycle of each accepted byte
  int         acc_s[$];   // its SETUP cycle
  logic [7:0] acc_d[$];
  int         ovr_cyc;    // first cycle a byte was dropped, -1 if none
  logic [7:0] dq_base;
  int         cyc = 0;
  bit         prev_rw;
  bit         clr_pend;
  bit         chk_en = 1'b0;

  task automatic model_reset();
    acc_e.delete(); acc_s.delete(); acc_d.delete();
    ovr_cyc = -1; dq_base = 8'h00; prev_rw = 1'b1; clr_pend = 1'b0;
  endtask

  function automatic logic [7:0] exp_dq(int t);
    logic [7:0] d = dq_base;
    foreach (acc_s[i]) if (acc_s[i] <= t) d = acc_d[i];
    return d;
  endfunction

  function automatic logic [51:0] exp_vec(int t);
    int done = 0; int act = -1; bit pend = 0; bit wn;
    logic [AW-1:0] ad;
    foreach (acc_s[i]) begin
      if (acc_s[i] + WP + 1 < t) done++;
      else if (acc_s[i] <= t) act = i;
      if (acc_s[i] > t && acc_e[i] < t) pend = 1;
    end
    wn = !(act >= 0 && t - acc_s[act] >= 1 && t - acc_s[act] <= WP);
    ad = (act >= 0) ? AW'(act) : AW'(done);
    return {ad, exp_dq(t), act >= 0, wn, (AW+1)'(done), (act >= 0) || pend, 1'b0,
            ovr_cyc >= 0 && ovr_cyc < t};
  endfunction

  task automatic model_step(bit rw, logic [7:0] d, bit clr);
    int occ, s;
    if (clr_pend) begin
      dq_base = exp_dq(cyc);
      acc_e.delete(); acc_s.delete(); acc_d.delete();
      ovr_cyc = -1; clr_pend = 1'b0;
    end
    cyc++;
    if (rw && !prev_rw && !clr) begin
      // A waiting byte whose SETUP is next cycle is leaving the slot right now.
      occ = 0;
      foreach (acc_s[i]) if (acc_s[i] > cyc + 1) occ++;
      if (occ == 0) begin
        s = cyc + 1;
        if (acc_s.size() > 0 && acc_s[$] + WP + 2 > s) s = acc_s[$] + WP + 2;
        acc_e.push_back(cyc); acc_s.push_back(s); acc_d.push_back(d);
      end else if (ovr_cyc < 0) begin
        ovr_cyc = cyc;
      end
    end
    if (clr) clr_pend = 1'b1;
    prev_rw = rw;
  endtask

  always @(negedge clock) begin
    if (chk_en)
      chk($sformatf("cycle%0d", cyc),
          longint'({a_addr, a_dq, a_oe, a_we_n, a_cnt, a_busy, a_full, a_ovr}),
          longint'(exp_vec(cyc)));
  end

  task automatic step(input bit rw, input logic [7:0] d, input bit clr);
    @(posedge clock); #1;
    if (!reset_n) begin reset_n = 1'b1; chk_en = 1'b1; end
    ram_write = rw; ram_data = d; clear = clr;
    model_step(rw, d, clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; ram_write = 1'b0; ram_data = 8'h00; clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_we_n", a_we_n, 1);  chk("rst_oe", a_oe, 0);    chk("rst_addr", a_addr, 0);
    chk("rst_dq", a_dq, 0);      chk("rst_cnt", a_cnt, 0);  chk("rst_busy", a_busy, 0);
    chk("rst_full_ovr", {a_full, a_ovr, b_full, b_ovr}, 0);
    idle(3);

    // Single byte 0xA5 from IDLE.
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("e1_setup", {a_oe, a_we_n, a_dq}, {2'b11, 8'hA5});  chk("e1_addr", a_addr, 0);
    step(1'b0, 8'h00, 1'b0);  chk("e2_we_low", a_we_n, 0);
    step(1'b0, 8'h00, 1'b0);  chk("e3_we_low", a_we_n, 0);
    step(1'b0, 8'h00, 1'b0);  chk("e4_hold", {a_oe, a_we_n, a_cnt[3:0]}, {2'b11, 4'd0});
    step(1'b0, 8'h00, 1'b0);
    chk("e5_done", {a_busy, a_oe, a_cnt[3:0], a_addr[3:0]}, {2'b00, 4'd1, 4'd1});
    chk("e5_mem0", mem_a[0], 8'hA5);

    // Strobes every 2 clocks. 0x03 arrives as 0x02 leaves the pending slot,
    // so it is kept; 0x04 finds both registers full and is dropped.
    step(1'b0, 8'h00, 1'b1); idle(2);
    for (int k = 0; k < 8; k++) step(k % 2 == 0, 8'(k / 2 + 1), 1'b0);
    chk("burst_ovr", a_ovr, 1);
    idle(16);
    chk("burst_cnt", a_cnt, 3);
    chk("burst_mem", {mem_a[0], mem_a[1], mem_a[2]}, 24'h010203);

    // Clear during the strobe of the second byte.
    step(1'b0, 8'h00, 1'b1); idle(2);
    step(1'b1, 8'h11, 1'b0); idle(6);
    step(1'b1, 8'h22, 1'b0); idle(1);
    step(1'b0, 8'h00, 1'b1);
    chk("clr_in_strobe", a_we_n, 0);
    step(1'b0, 8'h00, 1'b0);
    chk("clr_abort", {a_we_n, a_oe, a_cnt[3:0], a_addr[3:0]}, {2'b10, 4'd0, 4'd0});
    step(1'b1, 8'h33, 1'b0); step(1'b0, 8'h00, 1'b0);
    chk("clr_next_setup", {a_addr[3:0], a_dq}, {4'd0, 8'h33});
    idle(5);
    chk("clr_next_done", {a_cnt[3:0], mem_a[0]}, {4'd1, 8'h33});

    // 8-location SRAM: fill, then one more byte.
    step(1'b0, 8'h00, 1'b1); idle(2);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 8'(8'h40 + i), 1'b0); idle(5);
      if (i == 6) chk("full_not_yet", b_full, 0);
    end
    chk("full_flags", {b_full, b_ovr}, 2'b10);
    chk("full_cnt_addr", {b_cnt, b_addr}, {4'd8, 3'd7});
    for (int i = 0; i < 8; i++) chk($sformatf("full_mem%0d", i), mem_b[i], 8'h40 + i);

    // Reset pulse mid-strobe with ram_write held high across release.
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h5A, 1'b0); step(1'b1, 8'h00, 1'b0); step(1'b1, 8'h00, 1'b0);
    #1 reset_n = 1'b0; chk_en = 1'b0; model_reset();
    #1;
    chk("arst_out", {a_we_n, a_oe, a_busy, a_dq}, {3'b100, 8'h00});
    chk("arst_cnt_addr", {a_cnt[3:0], a_addr[3:0]}, 0);
    repeat (2) @(posedge clock);
    step(1'b1, 8'h66, 1'b0); step(1'b1, 8'h66, 1'b0); step(1'b1, 8'h66, 1'b0);
    chk("held_no_capture", a_busy, 0);
    step(1'b0, 8'h00, 1'b0); step(1'b1, 8'h77, 1'b0); idle(6);
    chk("post_rst_write", {a_cnt[3:0], mem_a[0]}, {4'd1, 8'h77});

    // Randomized strobe density with occasional clears.
    step(1'b0, 8'h00, 1'b1); idle(2);
    for (int blk = 0; blk < 6; blk++) begin
      for (int k = 0; k < 500; k++) begin
        int p;
        p = (blk % 3 == 0) ? 25 : (blk % 3 == 1) ? 50 : 85;
        step($urandom_range(0, 99) < p, 8'($urandom), $urandom_range(0, 299) == 0);
      end
    end
    idle(12);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
